seq_detector_n: RTL and testbench
=================================

# seq_detector_n

Parametrised serial pattern detector: the next generation of the 4-bit sequence identifier. It shifts a qualified serial bit stream into a SEQ_W-bit history window and compares the window against a programmable reference under a per-bit care mask. It supports overlapping and non-overlapping detection, suppresses matches until the window holds valid data, and keeps a saturating match counter. It sits on the serial receive path, where it feeds event pulses and statistics to control logic.

## Interface
- SEQ_W, 8, pattern length in bits; legal range 2..32
- CNT_W, 16, match counter width; legal range 1..32
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  bit_i valid this cycle; bit ignored when low
- bit_i  in  1  serial data bit
- ref_i  in  SEQ_W  reference pattern; bit 0 = most recent bit, bit SEQ_W-1 = oldest
- mask_i  in  SEQ_W  care mask; 1 = compare this position, 0 = don't care
- overlap_i  in  1  1 = overlapping detection, 0 = non-overlapping
- clear_i  in  1  synchronous clear of history, fill, counter and sticky flag
- flag_o  out  1  one-cycle match pulse, registered
- match_cnt_o  out  CNT_W  number of matches since reset/clear, saturating
- cnt_sat_o  out  1  sticky, set when a match occurs with the counter at all-ones

## Operation
- Window register win_q[SEQ_W-1:0] and fill counter fill_q (0..SEQ_W).
- On an en_i cycle:
  - next window = {win_q[SEQ_W-2:0], bit_i}.
  - fill_next = min(fill_q+1, SEQ_W).
- hit = en_i & (fill_next == SEQ_W) & (((next window ^ ref_i) & mask_i) == 0). The comparison includes the bit arriving this cycle.
- State, derived from fill_q (enum in the package):
  - EMPTY (fill 0) -> FILL on en_i.
  - FILL (0 < fill < SEQ_W) -> ARMED when fill_next reaches SEQ_W.
  - ARMED: hit evaluated on every en_i.
- On hit with overlap_i=0: fill_q is set to 0 (EMPTY). The window still shifts, but the next hit needs SEQ_W fresh bits.
- On hit with overlap_i=1: fill_q stays SEQ_W, so a hit is possible on every subsequent en_i.
- mask_i all-zero: every en_i in ARMED is a hit.
- ref_i, mask_i and overlap_i are sampled combinationally at each en_i. Changing them has no effect on stored history.
- Counter:
  - On hit, match_cnt_o increments.
  - At all-ones it holds, and cnt_sat_o is set.
  - cnt_sat_o is cleared only by rst_i or clear_i.
- Priority: rst_i > clear_i > en_i. When clear_i and en_i are both high, the bit is discarded and no hit is produced.
- en_i low: window, fill and counter hold; flag_o is 0 the next cycle.

## Timing
- Reset values: win_q=0, fill_q=0, flag_o=0, match_cnt_o=0, cnt_sat_o=0. No X on any output.
- Latency: flag_o is high for exactly the one cycle after the edge that samples the completing bit.
- match_cnt_o and cnt_sat_o update on the same edge as flag_o rises.
- clear_i or rst_i asserted in the cycle after a hit: flag_o still pulses for that cycle, because it is already registered. Counter and sticky read 0 the following cycle.
- Reset mid-pattern: partial history is lost and a full SEQ_W bits are required again.
- Back-to-back en_i with overlap_i=1 and a periodic pattern: flag_o may stay high on consecutive cycles, one pulse per hit.
- Throughput: one bit per cycle, no stall, no backpressure.

## Structure
- Package seq_pkg holds:
  - state enum seq_state_e {EMPTY, FILL, ARMED}.
  - localparams SEQ_W_MIN=2, SEQ_W_MAX=32.
  - fill-counter width function $clog2(SEQ_W+1).
- Elaboration-time check rejects SEQ_W or CNT_W outside the legal range.
- One sub-module, seq_match_cnt: the CNT_W saturating counter plus the sticky flag, with inputs inc, clr.
- Window, fill and compare logic stay in the top module.

## Test plan
Cases 1–5 use SEQ_W=4.
- Case 1: ref 4'b1011, mask 4'b1111, overlap 1, en_i constant, stream 1,0,1,1,0,1,1 -> flag_o pulses after the 4th and 7th bits; match_cnt_o=2.
- Case 2: same stream with overlap 0 -> single pulse after the 4th bit; match_cnt_o=1.
- Case 3: after reset, ref 4'b0000, mask 4'b1111, stream 0,0,0 -> no pulse; 4th 0 -> pulse; 5th 0 (overlap 1) -> pulse.
- Case 4: ref 4'b1001, mask 4'b1001, stream 1,1,0,1 -> pulse. Insert en_i=0 gaps of 3 cycles between bits -> same single pulse, delayed accordingly.
- Case 5: CNT_W=2, ref 4'b1111, overlap 1, seven 1s -> four hits. match_cnt_o goes 1,2,3,3 and cnt_sat_o rises on the 4th hit. Then clear_i with en_i high -> all zero, bit discarded.
- Case 6: SEQ_W=32, random stream with an embedded 32-bit ref and mask all-ones -> exactly one pulse at the embedding end. rst_i asserted at bit 16 of a second embedding -> no pulse.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and limits for the parametrised serial pattern detector.
package seq_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      ARMED = 2'd2
   } seq_state_e;

   localparam int SEQ_W_MIN = 2;
   localparam int SEQ_W_MAX = 32;
   localparam int CNT_W_MIN = 1;
   localparam int CNT_W_MAX = 32;

   // Fill counter must represent every value 0..seq_w inclusive.
   function automatic int fill_width(input int seq_w);
      return $clog2(seq_w + 1);
   endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with a sticky flag that records a match arriving
// while the counter already reads all-ones.
module seq_match_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   logic [CNT_W-1:0] cnt_q;
   logic             sat_q;

   // Count matches, holding at all-ones and latching the sticky flag there.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= {CNT_W{1'b0}};
         sat_q <= 1'b0;
      end else if (inc) begin
         if (&cnt_q) begin
            cnt_q <= cnt_q;
            sat_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1'b1);
            sat_q <= sat_q;
         end
      end else begin
         cnt_q <= cnt_q;
         sat_q <= sat_q;
      end
   end

   assign cnt = cnt_q;
   assign sat = sat_q;

endmodule

// File: rtl/seq_detector_n.sv
// Serial pattern detector: shifts qualified bits into a SEQ_W-bit window and
// flags matches against a masked reference, with a saturating match count.
module seq_detector_n
   import seq_pkg::*;
#(
   parameter int SEQ_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             bit_i,
   input  logic [SEQ_W-1:0] ref_i,
   input  logic [SEQ_W-1:0] mask_i,
   input  logic             overlap_i,
   input  logic             clear_i,
   output logic             flag_o,
   output logic [CNT_W-1:0] match_cnt_o,
   output logic             cnt_sat_o
);

   localparam int            FW        = fill_width(SEQ_W);
   localparam logic [FW-1:0] FILL_FULL = FW'(SEQ_W);
   localparam logic [FW-1:0] FILL_ZERO = {FW{1'b0}};
   localparam logic [FW-1:0] FILL_ONE  = FW'(1'b1);

   generate
      if (SEQ_W < SEQ_W_MIN || SEQ_W > SEQ_W_MAX) begin : g_bad_seq_w
         $error("seq_detector_n: SEQ_W outside legal range 2..32");
      end
      if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
         $error("seq_detector_n: CNT_W outside legal range 1..32");
      end
   endgenerate

   logic [SEQ_W-1:0] win_q;
   logic [SEQ_W-1:0] win_next;
   logic [SEQ_W-1:0] win_shift;
   logic [FW-1:0]    fill_q;
   logic [FW-1:0]    fill_next;
   logic [FW-1:0]    fill_sat;
   seq_state_e       state_q;
   seq_state_e       state_next;
   logic             hit;
   logic             flag_q;

   // Next window, fill level, state and match decision for the current cycle.
   always_comb begin
      win_shift  = {win_q[SEQ_W-2:0], bit_i};
      fill_sat   = (fill_q >= FILL_FULL) ? FILL_FULL : (fill_q + FILL_ONE);
      win_next   = win_q;
      fill_next  = fill_q;
      state_next = state_q;
      hit        = 1'b0;
      if (clear_i) begin
         win_next   = {SEQ_W{1'b0}};
         fill_next  = FILL_ZERO;
         state_next = EMPTY;
      end else if (en_i) begin
         win_next = win_shift;
         // The incoming bit takes part in the comparison.
         hit = (fill_sat == FILL_FULL) &&
               (((win_shift ^ ref_i) & mask_i) == {SEQ_W{1'b0}});
         case (state_q)
            EMPTY:   state_next = FILL;
            FILL:    state_next = (fill_sat == FILL_FULL) ? ARMED : FILL;
            ARMED:   state_next = ARMED;
            default: state_next = EMPTY;
         endcase
         if (hit && !overlap_i) begin
            fill_next  = FILL_ZERO;
            state_next = EMPTY;
         end else begin
            fill_next  = fill_sat;
         end
      end else begin
         win_next   = win_q;
         fill_next  = fill_q;
         state_next = state_q;
      end
   end

   // History window, fill level, state and the registered match pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_q   <= {SEQ_W{1'b0}};
         fill_q  <= FILL_ZERO;
         state_q <= EMPTY;
         flag_q  <= 1'b0;
      end else begin
         win_q   <= win_next;
         fill_q  <= fill_next;
         state_q <= state_next;
         flag_q  <= hit;
      end
   end

   seq_match_cnt #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .clr (clear_i),
      .inc (hit),
      .cnt (match_cnt_o),
      .sat (cnt_sat_o)
   );

   assign flag_o = flag_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Self-checking bench: a 4-bit/2-bit-counter instance and a 32-bit instance
// compared every cycle against a bit-history reference model.
module tb_seq_detector_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst = 1'b0, a_en = 1'b0, a_bit = 1'b0, a_ovl = 1'b0, a_clr = 1'b0;
   logic [3:0]  a_ref = 4'd0, a_mask = 4'd0;
   logic        a_flag, a_sat;
   logic [1:0]  a_cnt;

   logic        b_rst = 1'b0, b_en = 1'b0, b_bit = 1'b0, b_ovl = 1'b0, b_clr = 1'b0;
   logic [31:0] b_ref = 32'd0, b_mask = 32'd0;
   logic        b_flag, b_sat;
   logic [15:0] b_cnt;

   seq_detector_n #(.SEQ_W(4), .CNT_W(2)) dut_a (
      .clk_i(clk), .rst_i(a_rst), .en_i(a_en), .bit_i(a_bit), .ref_i(a_ref),
      .mask_i(a_mask), .overlap_i(a_ovl), .clear_i(a_clr), .flag_o(a_flag),
      .match_cnt_o(a_cnt), .cnt_sat_o(a_sat)
   );

   seq_detector_n #(.SEQ_W(32), .CNT_W(16)) dut_b (
      .clk_i(clk), .rst_i(b_rst), .en_i(b_en), .bit_i(b_bit), .ref_i(b_ref),
      .mask_i(b_mask), .overlap_i(b_ovl), .clear_i(b_clr), .flag_o(b_flag),
      .match_cnt_o(b_cnt), .cnt_sat_o(b_sat)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: raw bit history plus count of bits since the last
   // reset/clear/non-overlapping match.
   bit hist [2][64];
   int pos [2]   = '{0, 0};
   int fresh [2] = '{0, 0};
   int mcnt [2]  = '{0, 0};
   bit msat [2]  = '{1'b0, 1'b0};
   bit mflag [2] = '{1'b0, 1'b0};

   task automatic model(input int k, input int w, input int cmax, input bit rst,
                        input bit clr, input bit en, input bit b, input bit ovl,
                        input logic [31:0] rf, input logic [31:0] mk);
      bit ok;
      if (rst || clr) begin
         pos[k] = 0; fresh[k] = 0; mcnt[k] = 0; msat[k] = 1'b0; mflag[k] = 1'b0;
      end else if (en) begin
         hist[k][pos[k] % 64] = b;
         pos[k]++;
         fresh[k] = (fresh[k] + 1 > w) ? w : fresh[k] + 1;
         ok = (fresh[k] == w);
         if (ok) begin
            for (int i = 0; i < w; i++)
               if (mk[i] && (hist[k][(pos[k] - 1 - i) % 64] != rf[i])) ok = 1'b0;
         end
         mflag[k] = ok;
         if (ok) begin
            if (mcnt[k] == cmax) msat[k] = 1'b1;
            else mcnt[k]++;
            if (!ovl) fresh[k] = 0;
         end
      end else begin
         mflag[k] = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive both instances, then check every output against the model.
   task automatic step(input bit ae, input bit ab, input bit ac, input bit ar,
                       input bit be, input bit bb, input bit bc, input bit br);
      a_en = ae; a_bit = ab; a_clr = ac; a_rst = ar;
      b_en = be; b_bit = bb; b_clr = bc; b_rst = br;
      @(posedge clk);
      #1;
      model(0, 4, 3, ar, ac, ae, ab, a_ovl, {28'd0, a_ref}, {28'd0, a_mask});
      model(1, 32, 65535, br, bc, be, bb, b_ovl, b_ref, b_mask);
      chk("a_flag", {31'd0, a_flag}, {31'd0, mflag[0]});
      chk("a_cnt",  {30'd0, a_cnt},  mcnt[0]);
      chk("a_sat",  {31'd0, a_sat},  {31'd0, msat[0]});
      chk("b_flag", {31'd0, b_flag}, {31'd0, mflag[1]});
      chk("b_cnt",  {16'd0, b_cnt},  mcnt[1]);
      chk("b_sat",  {31'd0, b_sat},  {31'd0, msat[1]});
   endtask

   task automatic feed_a(input int n, input logic [31:0] bits, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b1, bits[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         for (int g = 0; g < gap; g++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic feed_b(input int n, input logic [31:0] bits);
      for (int i = n - 1; i >= 0; i--)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, bits[i], 1'b0, 1'b0);
   endtask

   task automatic reset_all();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [31:0] r;
      reset_all();
      reset_all();
      chk("rst_a_cnt", {30'd0, a_cnt}, 32'd0);

      // Case 1: overlapping 1011 in 1011011 -> two pulses
      a_ref = 4'b1011; a_mask = 4'b1111; a_ovl = 1'b1;
      feed_a(7, 32'b1011011, 0);
      chk("c1_cnt", {30'd0, a_cnt}, 32'd2);

      // Case 2: non-overlapping -> one pulse
      reset_all();
      a_ovl = 1'b0;
      feed_a(7, 32'b1011011, 0);
      chk("c2_cnt", {30'd0, a_cnt}, 32'd1);

      // Case 3: all-zero reference needs a full window first
      reset_all();
      a_ref = 4'b0000; a_ovl = 1'b1;
      feed_a(3, 32'b000, 0);
      chk("c3_nopulse", {31'd0, a_flag}, 32'd0);
      feed_a(1, 32'b0, 0);
      chk("c3_pulse4", {31'd0, a_flag}, 32'd1);
      feed_a(1, 32'b0, 0);
      chk("c3_pulse5", {31'd0, a_flag}, 32'd1);

      // Case 4: masked compare, then the same stream with 3-cycle en gaps
      reset_all();
      a_ref = 4'b1001; a_mask = 4'b1001;
      feed_a(4, 32'b1101, 0);
      chk("c4_pulse", {31'd0, a_flag}, 32'd1);
      reset_all();
      feed_a(4, 32'b1101, 3);
      chk("c4_gap_cnt", {30'd0, a_cnt}, 32'd1);

      // Case 5: saturation on the 2-bit counter, then clear with en high
      reset_all();
      a_ref = 4'b1111; a_mask = 4'b1111; a_ovl = 1'b1;
      feed_a(7, 32'b1111111, 0);
      chk("c5_cnt", {30'd0, a_cnt}, 32'd3);
      chk("c5_sat", {31'd0, a_sat}, 32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("c5_clr_cnt", {30'd0, a_cnt}, 32'd0);
      chk("c5_clr_sat", {31'd0, a_sat}, 32'd0);

      // Randomised traffic on the 4-bit instance
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            a_ref  = 4'($urandom_range(0, 15));
            a_mask = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            a_ovl  = 1'($urandom_range(0, 1));
         end
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
              1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Case 6: 32-bit embedded pattern, then reset mid-pattern
      reset_all();
      r = $urandom;
      b_ref = r; b_mask = 32'hFFFF_FFFF; b_ovl = 1'b0;
      feed_b(10, $urandom);
      feed_b(32, r);
      chk("c6_pulse", {31'd0, b_flag}, 32'd1);
      chk("c6_cnt", {16'd0, b_cnt}, 32'd1);
      feed_b(16, {16'd0, r[31:16]});
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      feed_b(16, {16'd0, r[15:0]});
      chk("c6_rst_cnt", {16'd0, b_cnt}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
